// File: rtl/pwm_duty_ctrl.sv
// Button-driven duty-cycle controller: synchronises and debounces inc/dec buttons, steps a
// saturating duty value per press with hold-to-repeat, and strobes each real change.
module pwm_duty_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned RESET_DUTY      = 8,
    parameter int unsigned STEP            = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_in,
    input  logic             dec_in,
    output logic [WIDTH-1:0] duty_out,
    output logic             duty_update,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    localparam logic [WIDTH:0]   DutyMax   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   StepW     = (WIDTH + 1)'(STEP);
    localparam logic [DbW-1:0]   DbLimit   = DbW'(DEBOUNCE_CYCLES);
    localparam logic [RepW-1:0]  RepDelay  = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0]  RepPeriod = RepW'(REPEAT_PERIOD);
    localparam logic [RepW-1:0]  RepOne    = RepW'(1);

    typedef enum logic [1:0] {StIdle, StHoldInc, StHoldDec, StBlock} state_e;

    // Bit 0 is the increase button, bit 1 the decrease button.
    logic [1:0]     raw;
    logic [1:0]     sync1_q, sync2_q, deb_q, rise_q;
    logic [DbW-1:0] db_cnt_q [2];

    state_e          state_q;
    logic [RepW-1:0] rep_q;
    logic [WIDTH-1:0] duty_q;
    logic            upd_q;

    logic [WIDTH:0]   up_sum, dn_diff;
    logic [WIDTH-1:0] duty_up, duty_dn;

    assign raw = {dec_in, inc_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            rise_q      <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                rise_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLimit) begin
                    deb_q[i]    <= sync2_q[i];
                    rise_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Widened by one bit so saturation is detected before the value could wrap.
    always_comb begin
        up_sum  = {1'b0, duty_q} + StepW;
        dn_diff = {1'b0, duty_q} - StepW;
        duty_up = (up_sum > DutyMax) ? DutyMax[WIDTH-1:0] : up_sum[WIDTH-1:0];
        duty_dn = ({1'b0, duty_q} < StepW) ? '0 : dn_diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            rep_q   <= '0;
            duty_q  <= WIDTH'(RESET_DUTY);
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (deb_q[0] && deb_q[1]) begin
                        state_q <= StBlock;
                    end else if (rise_q[0]) begin
                        duty_q  <= duty_up;
                        upd_q   <= (duty_up != duty_q);
                        rep_q   <= RepDelay;
                        state_q <= StHoldInc;
                    end else if (rise_q[1]) begin
                        duty_q  <= duty_dn;
                        upd_q   <= (duty_dn != duty_q);
                        rep_q   <= RepDelay;
                        state_q <= StHoldDec;
                    end
                end
                StHoldInc: begin
                    if (deb_q[1]) begin
                        rep_q   <= '0;
                        state_q <= StBlock;
                    end else if (!deb_q[0]) begin
                        state_q <= StIdle;
                    end else if (rep_q == RepOne) begin
                        duty_q <= duty_up;
                        upd_q  <= (duty_up != duty_q);
                        rep_q  <= RepPeriod;
                    end else begin
                        rep_q <= rep_q - RepOne;
                    end
                end
                StHoldDec: begin
                    if (deb_q[0]) begin
                        rep_q   <= '0;
                        state_q <= StBlock;
                    end else if (!deb_q[1]) begin
                        state_q <= StIdle;
                    end else if (rep_q == RepOne) begin
                        duty_q <= duty_dn;
                        upd_q  <= (duty_dn != duty_q);
                        rep_q  <= RepPeriod;
                    end else begin
                        rep_q <= rep_q - RepOne;
                    end
                end
                StBlock: begin
                    // Leaving only with both released forces a fresh press before any step.
                    if (!deb_q[0] && !deb_q[1]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign duty_out    = duty_q;
    assign duty_update = upd_q;
    assign at_max      = (duty_q == {WIDTH{1'b1}});
    assign at_min      = (duty_q == '0);

endmodule
